// File: rtl/palette_writer.sv
// palette_writer: loads a run of palette entries from a colour stream, packing pairs into 32-bit word writes.
// Optional idle-stream timeout is compiled in when PALETTE_WRITER_TIMEOUT_EN is defined.
module palette_writer #(
    parameter int PALETTE_LENGTH = 256,
    parameter int COLOR_BITS     = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IDX_BITS      = $clog2(PALETTE_LENGTH),
    localparam int ADDR_BITS     = $clog2(PALETTE_LENGTH * 2)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [IDX_BITS-1:0]            cmd_start_index,
    input  logic [IDX_BITS:0]              cmd_count,
    input  logic                           color_valid,
    output logic                           color_ready,
    input  logic [COLOR_BITS-1:0]          color_data,
    output logic [ADDR_BITS-1:0]           wr_addr,
    output logic [1:0][COLOR_BITS-1:0]     wr_data,
    output logic [1:0]                     wr_en,
    output logic                           busy,
    output logic                           done,
    output logic                           timed_out
);

    if (PALETTE_LENGTH < 2 || (PALETTE_LENGTH & (PALETTE_LENGTH - 1)) != 0) begin : g_bad_length
        $error("PALETTE_LENGTH must be a power of two and at least 2");
    end
    if (COLOR_BITS < 1 || COLOR_BITS > 16) begin : g_bad_color_bits
        $error("COLOR_BITS must be in 1..16");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be positive");
    end

    typedef enum logic [1:0] {
        IDLE,
        LANE0,
        LANE1
    } state_t;

    localparam logic [IDX_BITS:0] FULL_COUNT = (IDX_BITS + 1)'(PALETTE_LENGTH);

    state_t                       state, state_next;
    logic [IDX_BITS-1:0]          idx, idx_next;
    logic [IDX_BITS:0]            rem, rem_next;
    logic [COLOR_BITS-1:0]        lane0, lane0_next;
    logic                         lane0_held, lane0_held_next;
    logic [ADDR_BITS-1:0]         wr_addr_next;
    logic [1:0][COLOR_BITS-1:0]   wr_data_next;
    logic [1:0]                   wr_en_next;
    logic                         done_next;
    logic                         color_accept;
    logic [ADDR_BITS-1:0]         word_addr;

`ifdef PALETTE_WRITER_TIMEOUT_EN
    localparam int TO_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT_CYCLES - 1);

    logic [TO_BITS-1:0]           timer, timer_next;
    logic                         timed_out_next;
`endif

    assign cmd_ready    = (state == IDLE);
    assign color_ready  = (state != IDLE);
    assign busy         = (state != IDLE);
    assign color_accept = color_valid & color_ready;
    // Both lanes of a word share one byte address; the entry's low index bit selects the lane.
    assign word_addr    = ({1'b0, idx} >> 1) << 2;

    always_comb begin
        state_next      = state;
        idx_next        = idx;
        rem_next        = rem;
        lane0_next      = lane0;
        lane0_held_next = lane0_held;
        wr_addr_next    = word_addr;
        wr_data_next    = '0;
        wr_en_next      = 2'b00;
        done_next       = 1'b0;
`ifdef PALETTE_WRITER_TIMEOUT_EN
        timer_next      = timer;
        timed_out_next  = 1'b0;
`endif

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    idx_next        = cmd_start_index;
                    rem_next        = (cmd_count > FULL_COUNT) ? FULL_COUNT : cmd_count;
                    lane0_held_next = 1'b0;
`ifdef PALETTE_WRITER_TIMEOUT_EN
                    timer_next      = '0;
`endif
                    if (rem_next == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = cmd_start_index[0] ? LANE1 : LANE0;
                    end
                end
            end

            LANE0: begin
                if (color_accept) begin
                    idx_next = idx + 1'b1;
                    rem_next = rem - 1'b1;
                    if (rem == (IDX_BITS + 1)'(1)) begin
                        wr_data_next[0] = color_data;
                        wr_en_next      = 2'b01;
                        done_next       = 1'b1;
                        state_next      = IDLE;
                    end else begin
                        lane0_next      = color_data;
                        lane0_held_next = 1'b1;
                        state_next      = LANE1;
                    end
                end
            end

            LANE1: begin
                if (color_accept) begin
                    wr_data_next[1] = color_data;
                    // An odd start leaves lane0 of the first word untouched.
                    if (lane0_held) begin
                        wr_data_next[0] = lane0;
                        wr_en_next      = 2'b11;
                    end else begin
                        wr_en_next      = 2'b10;
                    end
                    lane0_held_next = 1'b0;
                    idx_next        = idx + 1'b1;
                    rem_next        = rem - 1'b1;
                    if (rem == (IDX_BITS + 1)'(1)) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = LANE0;
                    end
                end
            end

            default: state_next = IDLE;
        endcase

`ifdef PALETTE_WRITER_TIMEOUT_EN
        if (state != IDLE) begin
            if (color_accept) begin
                timer_next = '0;
            end else if (timer == TO_LAST) begin
                timer_next      = '0;
                timed_out_next  = 1'b1;
                done_next       = 1'b1;
                state_next      = IDLE;
                lane0_held_next = 1'b0;
                if (state == LANE1 && lane0_held) begin
                    wr_data_next[0] = lane0;
                    wr_en_next      = 2'b01;
                end
            end else begin
                timer_next = timer + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Write port outputs are registered, so they appear the cycle after the accepting handshake.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx        <= '0;
            rem        <= '0;
            lane0      <= '0;
            lane0_held <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_en      <= 2'b00;
            done       <= 1'b0;
        end else begin
            idx        <= idx_next;
            rem        <= rem_next;
            lane0      <= lane0_next;
            lane0_held <= lane0_held_next;
            wr_addr    <= wr_addr_next;
            wr_data    <= wr_data_next;
            wr_en      <= wr_en_next;
            done       <= done_next;
        end
    end

`ifdef PALETTE_WRITER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            timer     <= '0;
            timed_out <= 1'b0;
        end else begin
            timer     <= timer_next;
            timed_out <= timed_out_next;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

endmodule

// File: tb/tb_palette_writer.sv
// tb_palette_writer: table-driven command vectors with a write scoreboard, plus reset/abort/timeout sequences.
module tb_palette_writer;

    localparam int PL = 256;
    localparam int CB = 16;
    localparam int TO = 8;
    localparam int IB = 8;
    localparam int AB = 9;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic                     cmd_valid = 1'b0;
    logic                     cmd_ready;
    logic [IB-1:0]            cmd_start_index = '0;
    logic [IB:0]              cmd_count = '0;
    logic                     color_valid = 1'b0;
    logic                     color_ready;
    logic [CB-1:0]            color_data = '0;
    logic [AB-1:0]            wr_addr;
    logic [1:0][CB-1:0]       wr_data;
    logic [1:0]               wr_en;
    logic                     busy;
    logic                     done;
    logic                     timed_out;

    always #5 clk = ~clk;

    palette_writer #(
        .PALETTE_LENGTH (PL),
        .COLOR_BITS     (CB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_start_index (cmd_start_index),
        .cmd_count       (cmd_count),
        .color_valid     (color_valid),
        .color_ready     (color_ready),
        .color_data      (color_data),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_en           (wr_en),
        .busy            (busy),
        .done            (done),
        .timed_out       (timed_out)
    );

    typedef struct packed {
        logic [AB-1:0]      addr;
        logic [1:0][CB-1:0] data;
        logic [1:0]         en;
        logic               done;
        logic               tout;
    } wr_t;

    typedef struct {
        int            start;
        int            count;
        bit            stall;
        bit            poke;
        int            expWrites;
        logic [AB-1:0] firstAddr;
        logic [1:0]    firstEn;
        logic [AB-1:0] lastAddr;
        logic [1:0]    lastEn;
    } vec_t;

    wr_t           expQ[$];
    int            testsRun = 0;
    int            failCount = 0;
    int            writesSeen = 0;
    int            bareDones = 0;
    logic          doneSeen = 1'b0;
    logic [AB-1:0] firstAddrSeen = '0;
    logic [AB-1:0] lastAddrSeen = '0;
    logic [1:0]    firstEnSeen = '0;
    logic [1:0]    lastEnSeen = '0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [AB-1:0] addrOf(input int idx);
        return AB'((idx / 2) * 4);
    endfunction

    function automatic wr_t makeWrite(input int idx, input logic [CB-1:0] hi, input logic [CB-1:0] lo,
                                      input logic [1:0] en, input logic last, input logic tout);
        wr_t w;
        w.addr    = addrOf(idx);
        w.data[1] = hi;
        w.data[0] = lo;
        w.en      = en;
        w.done    = last;
        w.tout    = tout;
        return w;
    endfunction

    // Scoreboard: every write the DUT issues must match the next expected write in order.
    always @(negedge clk) begin
        wr_t got;
        wr_t want;
        if (reset_n && wr_en != 2'b00) begin
            got = {wr_addr, wr_data, wr_en, done, timed_out};
            if (writesSeen == 0) begin
                firstAddrSeen = wr_addr;
                firstEnSeen   = wr_en;
            end
            lastAddrSeen = wr_addr;
            lastEnSeen   = wr_en;
            writesSeen++;
            if (done) doneSeen = 1'b1;
            if (expQ.size() == 0) begin
                checkOutput("unexpected write", 64'(got), 64'(0));
            end else begin
                want = expQ.pop_front();
                checkOutput("write", 64'(got), 64'(want));
            end
        end else if (reset_n && done) begin
            doneSeen = 1'b1;
            bareDones++;
        end
    end

    task automatic applyStimulus(input vec_t v, input int vi);
        int            n;
        int            guard;
        int            idx;
        logic [CB-1:0] col;
        logic          pend;
        logic [CB-1:0] pendData;

        writesSeen = 0;
        doneSeen   = 1'b0;
        n = (v.count > PL) ? PL : v.count;

        cmd_start_index = IB'(v.start);
        cmd_count       = (IB + 1)'(v.count);
        cmd_valid       = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("cmd_ready before accept", 64'(cmd_ready), 64'(1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checkOutput("busy after accept", 64'(busy), 64'(n != 0));

        if (n == 0) begin
            checkOutput("zero-count done", 64'({done, wr_en}), 64'(3'b100));
            @(posedge clk); #1;
            checkOutput("zero-count done one cycle", 64'(done), 64'(0));
        end

        pend     = 1'b0;
        pendData = '0;
        for (int i = 0; i < n; i++) begin
            if (v.poke && i == 1) begin
                cmd_valid       = 1'b1;
                cmd_start_index = 8'd100;
                cmd_count       = 9'd7;
                for (int k = 0; k < 2; k++) begin
                    checkOutput("cmd_ready while busy", 64'(cmd_ready), 64'(0));
                    @(posedge clk); #1;
                end
                cmd_valid = 1'b0;
            end
            if (v.stall) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #1;
                end
            end
            col = (vi == 0) ? CB'((i + 1) * 'h1111) : CB'($urandom);
            idx = (v.start + i) % PL;
            color_valid = 1'b1;
            color_data  = col;
            guard = 0;
            while (!color_ready && guard < 50) begin
                @(posedge clk); #1;
                guard++;
            end
            if (guard >= 50) checkOutput("color_ready timeout", 64'(color_ready), 64'(1));
            if (idx % 2 == 1) begin
                expQ.push_back(makeWrite(idx, col, pend ? pendData : '0, pend ? 2'b11 : 2'b10, i == n - 1, 1'b0));
                pend = 1'b0;
            end else if (i == n - 1) begin
                expQ.push_back(makeWrite(idx, '0, col, 2'b01, 1'b1, 1'b0));
            end else begin
                pend     = 1'b1;
                pendData = col;
            end
            @(posedge clk); #1;
            color_valid = 1'b0;
        end

        guard = 0;
        while (!doneSeen && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("done seen", 64'(doneSeen), 64'(1));
        checkOutput("write count", 64'(writesSeen), 64'(v.expWrites));
        if (v.expWrites > 0) begin
            checkOutput("first write addr/en", 64'({firstAddrSeen, firstEnSeen}), 64'({v.firstAddr, v.firstEn}));
            checkOutput("last write addr/en", 64'({lastAddrSeen, lastEnSeen}), 64'({v.lastAddr, v.lastEn}));
        end
        checkOutput("queue drained", 64'(expQ.size()), 64'(0));
        checkOutput("idle after done", 64'({cmd_ready, busy}), 64'(2'b10));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[10];
        vec_t extra;
        int   cyc;

        vecs[0] = '{0,   4,   1'b0, 1'b0, 2,   9'h000, 2'b11, 9'h004, 2'b11};
        vecs[1] = '{5,   3,   1'b0, 1'b0, 2,   9'h008, 2'b10, 9'h00C, 2'b11};
        vecs[2] = '{255, 2,   1'b0, 1'b0, 2,   9'h1FC, 2'b10, 9'h000, 2'b01};
        vecs[3] = '{0,   0,   1'b0, 1'b0, 0,   9'h000, 2'b00, 9'h000, 2'b00};
        vecs[4] = '{0,   300, 1'b0, 1'b0, 128, 9'h000, 2'b11, 9'h1FC, 2'b11};
        vecs[5] = '{10,  1,   1'b1, 1'b0, 1,   9'h014, 2'b01, 9'h014, 2'b01};
        vecs[6] = '{3,   1,   1'b0, 1'b0, 1,   9'h004, 2'b10, 9'h004, 2'b10};
        vecs[7] = '{254, 5,   1'b1, 1'b0, 3,   9'h1FC, 2'b11, 9'h004, 2'b01};
        vecs[8] = '{7,   511, 1'b1, 1'b0, 129, 9'h00C, 2'b10, 9'h00C, 2'b01};
        vecs[9] = '{20,  6,   1'b1, 1'b1, 3,   9'h028, 2'b11, 9'h030, 2'b11};

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("reset state", 64'({cmd_ready, busy, wr_en, done, color_ready, timed_out}), 64'(7'b1000000));

        for (int v = 0; v < 10; v++) begin
            applyStimulus(vecs[v], v);
        end

        // Reset in the middle of a command with lane0 pending must drop it silently.
        cmd_start_index = 8'd0;
        cmd_count       = 9'd4;
        cmd_valid       = 1'b1;
        @(posedge clk); #1;
        cmd_valid   = 1'b0;
        color_valid = 1'b1;
        color_data  = 16'hABCD;
        @(posedge clk); #1;
        color_valid = 1'b0;
        reset_n     = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            checkOutput("no write during reset", 64'({wr_en, done}), 64'(0));
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("state after abort", 64'({cmd_ready, busy, wr_en, done}), 64'(5'b10000));

        extra = '{1, 1, 1'b0, 1'b0, 1, 9'h000, 2'b10, 9'h000, 2'b10};
        applyStimulus(extra, 10);

`ifdef PALETTE_WRITER_TIMEOUT_EN
        writesSeen      = 0;
        doneSeen        = 1'b0;
        cmd_start_index = 8'd0;
        cmd_count       = 9'd4;
        cmd_valid       = 1'b1;
        @(posedge clk); #1;
        cmd_valid   = 1'b0;
        color_valid = 1'b1;
        color_data  = 16'h1111;
        expQ.push_back(makeWrite(0, '0, 16'h1111, 2'b01, 1'b1, 1'b1));
        @(posedge clk); #1;
        color_valid = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (wr_en != 2'b00) begin
                cyc = c;
                break;
            end
        end
        checkOutput("timeout latency", 64'(cyc), 64'(TO));
        @(posedge clk); #1;
        checkOutput("timeout flush seen", 64'({doneSeen, writesSeen[7:0]}), 64'({1'b1, 8'd1}));
        checkOutput("idle after timeout", 64'({cmd_ready, busy, timed_out}), 64'(3'b100));
        checkOutput("timeout queue drained", 64'(expQ.size()), 64'(0));
`endif

        checkOutput("bare done count", 64'(bareDones), 64'(1));

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/palette_writer.md
Name: palette_writer

Overview:
- Upstream write-side loader for the indexed-colour palette RAM.
- Accepts a load command (start index, entry count) followed by a valid/ready stream of colours.
- Packs consecutive entries into 32-bit, two-colour word writes with per-lane enables.
- Drives the palette's wr_addr / wr_data / wr_en port directly; same clock as that port.

Parameters:
- PALETTE_LENGTH, 256, number of palette entries (power of two, >=2).
- COLOR_BITS, 16, bits per colour (<=16, so two colours fit one 32-bit word).
- TIMEOUT_CYCLES, 1024, idle-stream limit; used only with PALETTE_WRITER_TIMEOUT_EN.
- localparam IDX_BITS = $clog2(PALETTE_LENGTH).
- localparam ADDR_BITS = $clog2(PALETTE_LENGTH*2), byte address width.

Ports:
- clk  in  1  single clock; also drives the palette write clock.
- reset_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  load command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_start_index  in  IDX_BITS  first entry to write.
- cmd_count  in  IDX_BITS+1  entries to write.
- color_valid  in  1  colour stream valid.
- color_ready  out  1  colour stream ready.
- color_data  in  COLOR_BITS  colour for the current index.
- wr_addr  out  ADDR_BITS  byte address, word aligned: {index[IDX_BITS-1:1], 2'b00}.
- wr_data  out  2 x COLOR_BITS  packed [1:0][COLOR_BITS-1:0]; lane k = entry with index[0]==k.
- wr_en  out  2  per-lane write enable.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- timed_out  out  1  one-cycle pulse; only with the macro, otherwise tied 0.

Behaviour:
- Reset (reset_n low at a clk edge):
  - All outputs 0 except cmd_ready = 1; state IDLE.
  - A pending half-word is discarded, not written.
  - Reset mid-command aborts with no further writes.
- States: IDLE, LANE0, LANE1.
- IDLE:
  - cmd_ready = 1, color_ready = 0.
  - On cmd_valid & cmd_ready: latch idx = cmd_start_index and rem = min(cmd_count, PALETTE_LENGTH).
  - If rem == 0: pulse done next cycle, no writes, stay IDLE.
  - Otherwise set busy = 1 and go to LANE1 if idx[0] else LANE0.
- LANE0 / LANE1: color_ready = 1. A colour is accepted on color_valid & color_ready.
- LANE0 accept:
  - If rem == 1 (last entry): single-lane write, wr_en = 2'b01.
  - Otherwise store the colour in lane0, idx++, rem--, go to LANE1.
- LANE1 accept:
  - Issue a write at the current word address.
  - wr_en = 2'b11 if lane0 was stored in this command's current word, else 2'b01<<1 = 2'b10 (odd start).
  - Then idx++, rem--; go to LANE0 if rem != 0.
- Write timing:
  - wr_addr / wr_data / wr_en are registered and valid exactly one cycle after the accepting handshake.
  - wr_en is 0 in all other cycles.
  - Unwritten lane data is don't-care, but is driven 0.
- Completion:
  - When the final entry's write is issued, done pulses in the same cycle as that wr_en.
  - busy drops the same cycle; next state IDLE; cmd_ready = 1 in the following cycle.
- Wrap-around: idx increments modulo PALETTE_LENGTH. Index PALETTE_LENGTH-1 (lane1) is followed by index 0 (lane0) in a new word.
- Back-to-back: one colour per cycle sustained. The write rate is therefore one word every two cycles, and at most one write per cycle.
- Stalls: color_valid low simply holds the state; no partial write is issued.
- cmd_valid while busy is ignored (cmd_ready = 0).

Optional Feature:
- Macro: PALETTE_WRITER_TIMEOUT_EN.
- Defined:
  - A counter clears on every colour accept and counts cycles in LANE0/LANE1 with no accept.
  - When it reaches TIMEOUT_CYCLES, a stored lane0 colour (if any) is flushed as a single-lane write (wr_en = 2'b01) in the next cycle.
  - timed_out and done pulse with that write, or on the next cycle if nothing is pending.
  - The block then returns to IDLE.
- Undefined: no counter; the block waits indefinitely; timed_out = 0.

Test Plan:
- Reset: hold reset_n low 3 cycles, then release -> cmd_ready=1, busy=0, wr_en=0, done=0.
- start=0, count=4, colours 0x1111..0x4444 streamed back to back:
  - write 1: wr_addr=0x000, wr_data={0x2222,0x1111}, wr_en=11.
  - write 2: wr_addr=0x004, data={0x4444,0x3333}, wr_en=11.
  - done pulses with write 2.
- start=5, count=3:
  - write 1: addr 0x008, wr_en=10, lane1=A.
  - write 2: addr 0x00C, wr_en=11, data {C,B}.
- Wrap: start=255, count=2 -> addr 0x1FC wr_en=10, then addr 0x000 wr_en=01; done with the second write.
- count=0 -> done one cycle after accept, no wr_en. count=300 -> exactly 256 entries written, 128 writes.
- Stall + timeout (macro defined, TIMEOUT_CYCLES=8): start=0, count=4, send 1 colour then hold valid low -> after 8 idle cycles: addr 0x000, wr_en=01, timed_out=1, done=1, IDLE.
